// File: rtl/truth_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package truth_sweep_pkg;

  localparam int unsigned NUM_MINTERMS = 16;
  localparam int unsigned DEC_OUTS     = 8;
  localparam logic [DEC_OUTS-1:0] DEC_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sweep_state_t;

  // Number of set bits in a 16-bit word.
  function automatic logic [4:0] popcount16(input logic [NUM_MINTERMS-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_MINTERMS; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/dec3to8_al.sv
// Combinational 3-to-8 decoder with active-low outputs (74x138 style).
// Enabled only when G1=1 and G2A_n=G2B_n=0; A is the select MSB.
module dec3to8_al
  import truth_sweep_pkg::*;
(
  input  logic                G1,
  input  logic                G2A_n,
  input  logic                G2B_n,
  input  logic                A,
  input  logic                B,
  input  logic                C,
  output logic [DEC_OUTS-1:0] Y
);

  logic       w_en;
  logic [2:0] w_sel;

  assign w_en  = G1 & ~G2A_n & ~G2B_n;
  assign w_sel = {A, B, C};

  // Drive the selected output low when enabled; all outputs high otherwise.
  always_comb begin
    Y = DEC_IDLE;
    if (w_en) begin
      Y[w_sel] = 1'b0;
    end
  end

endmodule

// File: rtl/truth_sweep_ctrl.sv
// Truth-table sweep controller: walks index {x,y,z,w} through all 16
// minterms, evaluates f through an active-low 3-to-8 decoder gated by the
// latched minterm mask, and captures each value into table_out.
// Optional self-check outputs (pass, err_cnt) exist when the macro
// TRUTH_SWEEP_CHECK_EN is defined.
module truth_sweep_ctrl
  import truth_sweep_pkg::*;
#(
  parameter int STEP_DIV = 1,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_MINTERMS-1:0] minterm_mask,
  output logic                    x,
  output logic                    y,
  output logic                    z,
  output logic                    w,
  output logic [DEC_OUTS-1:0]     dec_y,
  output logic                    f_out,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_MINTERMS-1:0] table_out
`ifdef TRUTH_SWEEP_CHECK_EN
  ,
  output logic                    pass,
  output logic [4:0]              err_cnt
`endif
);

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DIV - 1);

  sweep_state_t            r_state;
  sweep_state_t            w_next;
  logic [3:0]              r_index;
  logic [CNT_W-1:0]        r_step;
  logic [NUM_MINTERMS-1:0] r_mask;
  logic [NUM_MINTERMS-1:0] r_table;

  logic w_tick;
  logic w_last_idx;
  logic w_accept;
  logic w_dec_g1;

  assign w_tick     = (r_step == STEP_LAST);
  assign w_last_idx = (r_index == 4'(NUM_MINTERMS - 1));
  assign w_accept   = (r_state == IDLE) && start;

  assign x = r_index[3];
  assign y = r_index[2];
  assign z = r_index[1];
  assign w = r_index[0];

  assign table_out = r_table;

  dec3to8_al u_dec (
    .G1    (w_dec_g1),
    .G2A_n (1'b0),
    .G2B_n (1'b0),
    .A     (x),
    .B     (y),
    .C     (z),
    .Y     (dec_y)
  );

  // Only the decoder line for {x,y,z} contributes; r_index equals {x,y,z,w}.
  assign f_out = ~dec_y[{x, y, z}] & r_mask[r_index];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and state-decoded outputs; abort outranks the final tick.
  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    done     = 1'b0;
    w_dec_g1 = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = SWEEP;
        end
      end
      SWEEP: begin
        busy     = 1'b1;
        w_dec_g1 = 1'b1;
        if (abort) begin
          w_next = IDLE;
        end else if (w_tick && w_last_idx) begin
          w_next = DONE;
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Sweep datapath: mask latch, step divider, index counter and table capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask  <= '0;
      r_index <= '0;
      r_step  <= '0;
      r_table <= '0;
    end else if (w_accept) begin
      r_mask  <= minterm_mask;
      r_index <= '0;
      r_step  <= '0;
      r_table <= '0;
    end else if ((r_state == SWEEP) && !abort) begin
      if (w_tick) begin
        r_step           <= '0;
        r_table[r_index] <= f_out;
        if (!w_last_idx) begin
          r_index <= r_index + 4'd1;
        end
      end else begin
        r_step <= r_step + CNT_W'(1);
      end
    end
  end

`ifdef TRUTH_SWEEP_CHECK_EN
  logic       r_pass;
  logic [4:0] r_err_cnt;

  assign pass    = r_pass;
  assign err_cnt = r_err_cnt;

  // Compare the captured table with the mask in DONE; clear on the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pass    <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_accept) begin
      r_pass    <= 1'b0;
      r_err_cnt <= '0;
    end else if (r_state == DONE) begin
      r_pass    <= (r_table == r_mask);
      r_err_cnt <= popcount16(r_table ^ r_mask);
    end
  end
`endif

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// Self-checking bench for truth_sweep_ctrl (STEP_DIV=1 and STEP_DIV=3 instances).
module tb_truth_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort;
  logic [15:0] mask;
  logic        x, y, z, w, f_out, busy, done;
  logic [7:0]  dec_y;
  logic [15:0] table_out;

  logic        start3, abort3;
  logic [15:0] mask3;
  logic        x3, y3, z3, w3, f_out3, busy3, done3;
  logic [7:0]  dec_y3;
  logic [15:0] table_out3;

`ifdef TRUTH_SWEEP_CHECK_EN
  logic       pass, pass3;
  logic [4:0] err_cnt, err_cnt3;
`endif

  truth_sweep_ctrl #(.STEP_DIV(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .minterm_mask(mask),
    .x(x), .y(y), .z(z), .w(w), .dec_y(dec_y), .f_out(f_out),
    .busy(busy), .done(done), .table_out(table_out)
`ifdef TRUTH_SWEEP_CHECK_EN
    , .pass(pass), .err_cnt(err_cnt)
`endif
  );

  truth_sweep_ctrl #(.STEP_DIV(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3), .minterm_mask(mask3),
    .x(x3), .y(y3), .z(z3), .w(w3), .dec_y(dec_y3), .f_out(f_out3),
    .busy(busy3), .done(done3), .table_out(table_out3)
`ifdef TRUTH_SWEEP_CHECK_EN
    , .pass(pass3), .err_cnt(err_cnt3)
`endif
  );

  typedef struct {
    logic [15:0] mask;
    logic [15:0] exp_table;
  } vec_t;

  vec_t       vecs[5];
  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] dec_seen[16];
  logic       f_seen[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one sweep on the STEP_DIV=1 instance. cyc=1 is the first cycle after
  // the start edge. ev_kind: 1=abort, 2=extra start, 3=rst, applied while
  // index ev_at is presented.
  task automatic sweep1(input logic [15:0] m, input int ev_at, input int ev_kind,
                        output int cyc, output bit got_done);
    logic [3:0] idx;
    mask  = m;
    start = 1'b1;
    step();
    start    = 1'b0;
    cyc      = 1;
    got_done = 1'b0;
    while (cyc < 40) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (!busy) break;
      idx           = {x, y, z, w};
      dec_seen[idx] = dec_y;
      f_seen[idx]   = f_out;
      if (int'(idx) == ev_at) begin
        case (ev_kind)
          1:       abort = 1'b1;
          2:       start = 1'b1;
          3:       rst   = 1'b1;
          default: ;
        endcase
      end
      step();
      abort = 1'b0;
      start = 1'b0;
      rst   = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         cyc;
    bit         got;
    int         busycnt, holderr, donecnt;
    logic [7:0] e_dec;

    vecs[0] = '{16'h54AA, 16'h54AA};
    vecs[1] = '{16'h0000, 16'h0000};
    vecs[2] = '{16'hFFFF, 16'hFFFF};
    vecs[3] = '{16'h8001, 16'h8001};
    vecs[4] = '{16'h3C69, 16'h3C69};

    rst = 1'b1; start = 1'b0; abort = 1'b0; mask = '0;
    start3 = 1'b0; abort3 = 1'b0; mask3 = '0;
    repeat (3) step();

    chk("rst_index", {x, y, z, w}, 4'h0);
    chk("rst_dec_y", dec_y, 8'hFF);
    chk("rst_f_out", f_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_table", table_out, 16'h0000);
    rst = 1'b0;
    step();

    // Table-driven full sweeps.
    for (int i = 0; i < 5; i++) begin
      sweep1(vecs[i].mask, -1, 0, cyc, got);
      chk("done_seen", got, 1'b1);
      chk("done_cycle", cyc, 17);
      chk("table", table_out, vecs[i].exp_table);
      for (int k = 0; k < 16; k++) begin
        e_dec = ~(8'h01 << (k / 2));
        chk("dec_walk", dec_seen[k], e_dec);
        chk("f_walk", f_seen[k], vecs[i].exp_table[k]);
      end
      if (i == 0) begin
        chk("dec_idx5", dec_seen[5], 8'hFB);
        chk("f_idx5", f_seen[5], 1'b1);
        chk("f_idx4", f_seen[4], 1'b0);
      end
      step();
      chk("done_pulse_width", done, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_dec_y", dec_y, 8'hFF);
      chk("idle_f_out", f_out, 1'b0);
      chk("idle_index_hold", {x, y, z, w}, 4'hF);
    end

    // Extra start mid-sweep is ignored.
    sweep1(16'h54AA, 3, 2, cyc, got);
    chk("restart_ignored_cycle", cyc, 17);
    chk("restart_ignored_table", table_out, 16'h54AA);
    step();

    // Abort during the tick of index 6.
    sweep1(16'h54AA, 6, 1, cyc, got);
    chk("abort_no_done", got, 1'b0);
    chk("abort_cycle", cyc, 8);
    chk("abort_busy", busy, 1'b0);
    chk("abort_table", table_out, 16'h002A);
    chk("abort_dec_y", dec_y, 8'hFF);
    chk("abort_f_out", f_out, 1'b0);
    donecnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) donecnt++;
      step();
    end
    chk("abort_no_late_done", donecnt, 0);

    // Reset at index 9, then a clean sweep.
    sweep1(16'h54AA, 9, 3, cyc, got);
    chk("midrst_index", {x, y, z, w}, 4'h0);
    chk("midrst_dec_y", dec_y, 8'hFF);
    chk("midrst_f_out", f_out, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_table", table_out, 16'h0000);
    step();
    sweep1(16'h0F0F, -1, 0, cyc, got);
    chk("post_rst_cycle", cyc, 17);
    chk("post_rst_table", table_out, 16'h0F0F);
    step();

    // Held start re-triggers on the first IDLE cycle after DONE.
    mask  = 16'h00FF;
    start = 1'b1;
    cyc   = 0;
    while (!done && cyc < 40) begin
      step();
      cyc++;
    end
    chk("held_done_cycle", cyc, 17);
    chk("held_table", table_out, 16'h00FF);
    step();
    chk("held_idle_busy", busy, 1'b0);
    chk("held_idle_done", done, 1'b0);
    step();
    chk("held_retrigger_busy", busy, 1'b1);
    chk("held_retrigger_table_clear", table_out, 16'h0000);
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("held_abort_busy", busy, 1'b0);
    step();

    // STEP_DIV=3 instance.
    mask3  = 16'hA5A5;
    start3 = 1'b1;
    step();
    start3  = 1'b0;
    cyc     = 1;
    busycnt = 0;
    holderr = 0;
    while (!done3 && cyc < 200) begin
      if (busy3) busycnt++;
      if ({x3, y3, z3, w3} != 4'((cyc - 1) / 3)) holderr++;
      step();
      cyc++;
    end
    chk("div3_done", done3, 1'b1);
    chk("div3_done_cycle", cyc, 49);
    chk("div3_busy_cycles", busycnt, 48);
    chk("div3_index_hold", holderr, 0);
    chk("div3_table", table_out3, 16'hA5A5);
    step();

`ifdef TRUTH_SWEEP_CHECK_EN
    sweep1(16'h54AA, -1, 0, cyc, got);
    step();
    chk("chk_pass_ok", pass, 1'b1);
    chk("chk_err_ok", err_cnt, 5'd0);
    force dut.w_dec_g1 = 1'b0;
    sweep1(16'h54AA, -1, 0, cyc, got);
    step();
    release dut.w_dec_g1;
    chk("chk_forced_table", table_out, 16'h0000);
    chk("chk_pass_bad", pass, 1'b0);
    chk("chk_err_bad", err_cnt, 5'd7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/truth_sweep_ctrl.md
Name: truth_sweep_ctrl

Overview:
- Sequencer that drives the 4-input decoder-based function datapath (3-to-8 active-low decoder on x,y,z plus w gating) through all 16 minterms, one step at a time.
- Captures the evaluated output into a 16-bit truth table.
- Used on the lab board to exercise a programmed minterm list automatically and report the resulting table, instead of toggling switches by hand.
- Start/busy/done handshake toward the board-level control logic.

Parameters:
- STEP_DIV, 1, clock cycles spent on each minterm; legal range is 1..65535.
- CNT_W, 16, width of the step-divider counter; must satisfy 2^CNT_W > STEP_DIV.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a sweep; sampled only in IDLE.
- abort  in  1  terminate a sweep in progress.
- minterm_mask  in  16  bit k=1 means minterm k is in the function; captured on the start-accept cycle.
- x, y, z, w  out  1 each  current decoder address and w; index = {x,y,z,w}, with x as MSB.
- dec_y  out  8  active-low decoder outputs, as produced by the sub-module.
- f_out  out  1  function value for the current index.
- busy  out  1  high in SWEEP.
- done  out  1  one-cycle pulse when a full sweep completes.
- table_out  out  16  captured truth table; bit k = f(index k).

Behaviour:
- Reset values: x=y=z=w=0, dec_y=8'hFF, f_out=0, busy=0, done=0, table_out=16'h0000. State=IDLE; step and index counters=0.
- States and transitions:
  - IDLE: start=1 → SWEEP. On the same edge: latch minterm_mask, set index=0, step counter=0, clear table_out.
  - SWEEP: decoder enable is active (G1=1, G2A=G2B=0). The step counter counts 0..STEP_DIV-1. On its last cycle (the tick):
    - table_out[index] <= f_out.
    - If index=15 → DONE; otherwise index increments.
  - DONE: done=1 for exactly one cycle → IDLE. start is ignored in DONE.
- Decoder function: i={x,y,z}; dec_y[i]=0, all other bits 1.
- Function evaluation, combinational from the registered index: f_out = ~dec_y[i] & latched_mask[{i,w}]. There are no dec_y terms other than dec_y[i]. f_out=0 whenever the decoder is disabled.
- Outside SWEEP: decoder disabled, so dec_y=8'hFF and f_out=0. x,y,z,w hold their last value.
- Latency:
  - busy rises on the cycle after start is accepted.
  - Sweep length is exactly 16*STEP_DIV cycles.
  - done asserts the cycle after the final tick. With STEP_DIV=1, done is high 17 cycles after the start edge.
- Handshake:
  - start while busy or done is ignored; it is not queued.
  - A held-high start re-triggers on the first IDLE cycle after DONE.
- abort:
  - abort=1 in SWEEP → IDLE on the next edge. No done pulse; table_out keeps its partial contents.
  - abort has priority over a simultaneous tick. The bit at that tick is not written.
  - abort in IDLE or DONE has no effect.
- rst mid-sweep returns all state and outputs to reset values on the next edge. rst has priority over abort and start.
- Wrap-around: index never wraps inside a sweep; it stops at 15.

Optional Feature:
- Macro: TRUTH_SWEEP_CHECK_EN.
- When defined:
  - Adds outputs pass (1) and err_cnt (5).
  - At DONE, table_out is compared with the latched mask. pass=1 if they are equal; err_cnt = popcount(table_out ^ mask).
  - Both outputs are held until the next start accept, which clears them to 0. Reset values are 0.
- When undefined: the ports and the comparison logic are absent. All other behaviour is identical.

Decomposition:
- Shared package truth_sweep_pkg:
  - state enum {IDLE, SWEEP, DONE}.
  - constants NUM_MINTERMS=16, DEC_OUTS=8, DEC_IDLE=8'hFF.
- One sub-module: dec3to8_al. A combinational 3-to-8 active-low decoder with enables G1, G2A_n, G2B_n and select A,B,C, where A is the MSB. Instantiated once.

Test Plan:
- Basic sweep: mask=16'h54AA, STEP_DIV=1, pulse start → done at cycle 17, table_out=16'h54AA. At index 5: dec_y=8'hFB, f_out=1. At index 4: f_out=0.
- Edge masks: mask=16'h0000 → table_out=16'h0000. mask=16'hFFFF → table_out=16'hFFFF. dec_y walks FE,FE,FD,FD,…,7F,7F.
- Step divider: STEP_DIV=3 → busy high for exactly 48 cycles, each index held 3 cycles, done at cycle 49.
- Abort: mask=16'h54AA, abort asserted in the tick cycle of index 6 → no done, busy=0 next cycle, table_out=16'h002A, dec_y=8'hFF.
- Ignored start and reset: start pulsed again mid-sweep → no restart, result unchanged. rst at index 9 → all outputs at reset values next cycle; a following start runs a clean full sweep.
- With TRUTH_SWEEP_CHECK_EN: normal sweep → pass=1, err_cnt=0. Force the dec3to8_al enable low via a bench hook → pass=0, err_cnt=7 for mask 16'h54AA.
